// File: rtl/mdu_pkg.sv
// Shared MDU constants: md_op codes, FSM state encoding, counter width.
// Imported by mdu_arith and mdu_hilo_unit.
package mdu_pkg;

  localparam int CNT_W = 5;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MSUB  = 3'd7;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: {hi,lo} result for md_op on a/b (and hi/lo
// for MADD/MSUB when MDU_MADD_EN is defined). Ports: md_op,a,b,hi,lo -> res.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        b_zero;
  logic        s_ovf;

  assign b_zero = (b == 32'd0);
  assign s_ovf  = (a == 32'h8000_0000) &&
                  (b == 32'hFFFF_FFFF);

  always_comb begin
    sprod = $signed({{32{a[31]}}, a}) *
            $signed({{32{b[31]}}, b});
    uprod = {32'd0, a} * {32'd0, b};
    sq = '0;
    sr = '0;
    uq = '0;
    ur = '0;
    if (!b_zero) begin
      uq = a / b;
      ur = a % b;
      if (!s_ovf) begin
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
      end
    end
  end

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`else
  logic unused_hilo;
  assign unused_hilo = ^{hi, lo};
`endif

  always_comb begin
    res = '0;
    unique case (1'b1)
      (md_op == MD_MULT):  res = sprod;
      (md_op == MD_MULTU): res = uprod;
      (md_op == MD_DIV): begin
        if (b_zero)
          res = {a, 32'hFFFF_FFFF};
        else if (s_ovf)
          res = {32'd0, 32'h8000_0000};
        else
          res = {sr, sq};
      end
      (md_op == MD_DIVU): begin
        if (b_zero)
          res = {a, 32'hFFFF_FFFF};
        else
          res = {ur, uq};
      end
`ifdef MDU_MADD_EN
      (md_op == MD_MADD): res = acc + sprod;
      (md_op == MD_MSUB): res = acc - sprod;
`endif
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo_unit.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency ops plus D stall.
// Ports: clk,rst_n,start,md_op,a,b,md_use_d -> busy,stall_d,hi,lo. Opt: MDU_MADD_EN.
module mdu_hilo_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        op_mul;
  logic        op_div;
  logic        op_mac;
  logic        op_long;
  logic        go;
  logic [63:0] res;

  assign op_mul = (md_op == MD_MULT) |
                  (md_op == MD_MULTU);
  assign op_div = (md_op == MD_DIV) |
                  (md_op == MD_DIVU);
`ifdef MDU_MADD_EN
  assign op_mac = (md_op == MD_MADD) |
                  (md_op == MD_MSUB);
`else
  assign op_mac = 1'b0;
`endif
  assign op_long = op_mul | op_div | op_mac;

  assign busy    = (state_q == ST_RUN);
  assign go      = start & ~busy & op_long;
  assign stall_d = md_use_d & (busy | (start & op_long));
  assign hi      = hi_q;
  assign lo      = lo_q;

  mdu_arith u_arith (
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .hi    (hi_q),
    .lo    (lo_q),
    .res   (res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          pend_d  = res;
          cnt_d   = op_div ? CNT_W'(DIV_CYCLES)
                           : CNT_W'(MULT_CYCLES);
          state_d = ST_RUN;
        end else if (start) begin
          if (md_op == MD_MTHI) hi_d = a;
          if (md_op == MD_MTLO) lo_d = a;
        end
      end
      ST_RUN: begin
        // Requests arriving here are dropped on purpose.
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: vector table plus
// hand sequences for reset, stall, MTHI/MTLO and ignored starts.
module tb_mdu_hilo_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
  logic        busy;
  logic        stall_d;
  logic [31:0] hi;
  logic [31:0] lo;

  int pass_cnt = 0;
  int total    = 0;

  mdu_hilo_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_d  (stall_d),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic        use_d;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] aa,
                        input logic [31:0] bb,
                        input int n,
                        input logic use_d,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input string nm);
    @(negedge clk);
    start = 1'b1; md_op = op; a = aa; b = bb;
    md_use_d = use_d;
    #1 chk({nm, " stall_issue"}, 64'(stall_d), 64'(use_d));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk({nm, " busy"}, 64'(busy), 64'd1);
      chk({nm, " stall_run"}, 64'(stall_d), 64'(use_d));
    end
    @(negedge clk);
    chk({nm, " busy_done"}, 64'(busy), 64'd0);
    chk({nm, " stall_done"}, 64'(stall_d), 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    md_use_d = 1'b0;
  endtask

  task automatic mt(input logic [2:0] op,
                    input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; md_op = op; a = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    vt[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3, MC, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vt[1]  = '{3'd1, 32'hFFFF_FFFE, 32'd3, MC, 1'b1,
               32'h0000_0002, 32'hFFFF_FFFA};
    vt[2]  = '{3'd0, 32'd3, 32'd4, MC, 1'b0,
               32'h0, 32'hC};
    vt[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2, DC, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[4]  = '{3'd3, 32'd7, 32'd0, DC, 1'b0,
               32'd7, 32'hFFFF_FFFF};
    vt[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 1'b0,
               32'h0, 32'h8000_0000};
    vt[6]  = '{3'd3, 32'd100, 32'd7, DC, 1'b0,
               32'd2, 32'd14};
    vt[7]  = '{3'd2, 32'd7, 32'hFFFF_FFFE, DC, 1'b0,
               32'd1, 32'hFFFF_FFFD};
    vt[8]  = '{3'd2, 32'hFFFF_FFFB, 32'd0, DC, 1'b0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vt[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001};
    vt[10] = '{3'd0, 32'h8000_0000, 32'h8000_0000, MC, 1'b0,
               32'h4000_0000, 32'h0};

    rst_n = 1'b0; start = 1'b0; md_op = 3'd0;
    a = '0; b = '0; md_use_d = 1'b1;
    #12;
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst stall", 64'(stall_d), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    md_use_d = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].n,
             vt[i].use_d, vt[i].hi, vt[i].lo,
             $sformatf("vec%0d", i));

    // MTLO in idle: immediate, no busy, no stall
    @(negedge clk);
    start = 1'b1; md_op = 3'd5; a = 32'h1234;
    md_use_d = 1'b1;
    #1 chk("mtlo stall", 64'(stall_d), 64'd0);
    @(negedge clk);
    start = 1'b0; md_use_d = 1'b0;
    chk("mtlo lo", 64'(lo), 64'h1234);
    chk("mtlo hi", 64'(hi), 64'h4000_0000);
    chk("mtlo busy", 64'(busy), 64'd0);

    // MTHI and MULT issued during a DIV run are dropped
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; a = 32'd17; b = 32'd5;
    for (int i = 0; i < DC; i++) begin
      @(negedge clk);
      start = (i == 2) || (i == 3);
      md_op = (i == 2) ? 3'd4 : 3'd0;
      a = (i == 2) ? 32'hDEAD_BEEF : 32'd9;
      b = 32'd9;
      #1 chk("ign busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    start = 1'b0;
    chk("ign busy_done", 64'(busy), 64'd0);
    chk("ign hi", 64'(hi), 64'd2);
    chk("ign lo", 64'(lo), 64'd3);
    @(negedge clk);
    chk("ign no_restart", 64'(busy), 64'd0);

`ifdef MDU_MADD_EN
    mt(3'd4, 32'h0);
    mt(3'd5, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd1, 32'd1, MC, 1'b0,
           32'd1, 32'd0, "madd");
    run_op(3'd7, 32'd1, 32'd1, MC, 1'b0,
           32'd0, 32'hFFFF_FFFF, "msub");
`else
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      start = 1'b1; md_op = 3'(k);
      a = 32'd5; b = 32'd5; md_use_d = 1'b1;
      #1 chk("rsv stall", 64'(stall_d), 64'd0);
      @(negedge clk);
      start = 1'b0; md_use_d = 1'b0;
      chk("rsv busy", 64'(busy), 64'd0);
      chk("rsv hi", 64'(hi), 64'd2);
      chk("rsv lo", 64'(lo), 64'd3);
    end
`endif

    // Async reset in the middle of MULT 3*4
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst hi", 64'(hi), 64'd0);
    chk("arst lo", 64'(lo), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst late hi", 64'(hi), 64'd0);
    chk("arst late lo", 64'(lo), 64'd0);
    chk("arst late busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Multi-cycle multiply/divide unit owning the HI/LO registers. It sits in the E stage beside the ALU.
- It is the producer side of the pipeline's operand-hazard handling. Forwarding control routes in-flight GPR results to consumers. This block produces HI/LO results after a fixed latency and raises the D-stage stall that holds mult/div/mfhi/mflo consumers until HI/LO are valid.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..31).
- DIV_CYCLES, 10, busy cycles for div/divu (1..31).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  E-stage instruction is an MDU op; qualifies md_op. Already forwarded operands arrive on a/b.
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (MADD/MSUB when feature enabled).
- a  in  32  rs operand (forwarded).
- b  in  32  rt operand (forwarded).
- md_use_d  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in progress.
- stall_d  out  1  combinational: md_use_d & (busy | (start & md_op<=3)).
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n low):
  - hi=0, lo=0, busy=0.
  - Counter=0, pending result cleared.
  - stall_d follows its equation; it is 0 unless md_use_d & start.
  - Reset mid-operation aborts the op; HI/LO stay 0.
- State machine: IDLE, RUN.
  - IDLE, start & md_op in {0..3} at edge T: latch pending result, computed from a/b by the arith sub-module; load counter with N (MULT_CYCLES or DIV_CYCLES); go to RUN. busy=1 from T+1.
  - RUN: counter decrements each edge. At the edge where counter==1, hi/lo take the pending result, busy->0, state->IDLE.
  - Net timing: busy high exactly N cycles (T+1..T+N); new HI/LO visible from T+N+1.
  - MTHI/MTLO in IDLE: hi (resp. lo) <= a at the same edge; busy stays 0; no latency.
  - start while busy: ignored entirely. The pipeline never issues this because stall_d holds the consumer. Verification checks it is ignored, not corrupted.
  - Reserved md_op values: ignored.
- Arithmetic:
  - MULT: signed 32x32->64, hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32->64.
  - DIV: lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (DIV/DIVU, b==0): lo=32'hFFFFFFFF, hi=a; latency unchanged.
  - DIV overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- hi/lo are register outputs only; mfhi/mflo read them directly in E after the stall clears. No internal bypass.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - md_op 6 = MADD: {hi,lo} <= {hi,lo} + signed(a*b).
  - md_op 7 = MSUB: {hi,lo} <= {hi,lo} - signed(a*b).
  - Both use MULT_CYCLES latency. The accumulate base is HI/LO sampled at start, wrapping mod 2^64.
- Undefined: md_op 6/7 are ignored like other reserved codes.

Decomposition:
- Package mdu_pkg: md_op code constants (MD_MULT..MD_MSUB), state encoding (ST_IDLE, ST_RUN), counter width constant (5).
- Sub-module mdu_arith: purely combinational.
  - Inputs: md_op, a, b, current hi/lo.
  - Output: 64-bit {hi,lo} result, including the divide-by-zero and overflow rules.
- mdu_hilo_unit holds the FSM, counter, pending register and HI/LO.

Test Plan:
- Reset: rst_n low mid-RUN after MULT 3*4 -> hi=0, lo=0, busy=0 immediately, asynchronously; no late update after release.
- MULT latency: start, MULT a=32'hFFFFFFFE (-2), b=3 at T -> busy high T+1..T+5; at T+6 hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- DIV signed: a=-7, b=2 -> after 10 busy cycles lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
- Stall: md_use_d=1 during RUN -> stall_d=1 every busy cycle; stall_d=0 the cycle busy drops. md_use_d=1 with start&MULT in IDLE -> stall_d=1 combinationally.
- MTHI/MTLO and ignored start: MTLO a=32'h1234 in IDLE -> lo=32'h1234 next edge, busy stays 0. MTHI issued during a DIV RUN -> ignored; final hi is the DIV remainder.
- MDU_MADD_EN: hi=0, lo=32'hFFFFFFFF, MADD a=1, b=1 -> after 5 cycles hi=1, lo=0.
